// File: rtl/pmod_btn_pkg.sv
// Shared types and defaults for the PMOD button reader.
// Optional auto-repeat is enabled by defining PMOD_BTN_AUTOREPEAT_EN.
package pmod_btn_pkg;
  localparam int EVT_ID_W         = 3;
  localparam int DEF_TICK_DIV     = 10;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_REPEAT_DELAY = 32;
  localparam int DEF_REPEAT_RATE  = 8;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_SHOW = 1'b1
  } evt_state_t;
endpackage

// File: rtl/pmod_btn_debounce.sv
// One channel: 2-flop synchroniser, tick-based debouncer, press/release strobes.
// With PMOD_BTN_AUTOREPEAT_EN a hold counter re-strobes press while held.
module pmod_btn_debounce
  import pmod_btn_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
`ifdef PMOD_BTN_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic pin_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

  logic       sync1, sync2;
  logic       raw;
  logic [3:0] cnt;
  logic       flip;
  logic       rep_hit;

  // Sync flops reset to the released (high) pin level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_n;
      sync2 <= sync1;
    end
  end

  assign raw  = ~sync2;
  assign flip = tick && (raw != level) && (cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      if (tick) begin
        if ((raw == level) || (cnt == CNT_LAST)) cnt <= '0;
        else                                     cnt <= cnt + 4'd1;
      end
      if (flip) level <= raw;
      press <= (flip && raw) || rep_hit;
      rel   <= flip && !raw;
    end
  end

`ifdef PMOD_BTN_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [HOLD_W-1:0] hold;

  // Reloading to DELAY-RATE makes later repeats land every REPEAT_RATE ticks.
  assign rep_hit = tick && level && !flip && (hold == HOLD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold <= '0;
    end else if (flip || !level) begin
      hold <= '0;
    end else if (tick) begin
      hold <= rep_hit ? HOLD_RELOAD : hold + 1'b1;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif
endmodule

// File: rtl/pmod_btn_reader.sv
// PMOD button reader: per-pin debounce, pending edge events, valid/ready event port.
// Define PMOD_BTN_AUTOREPEAT_EN to add press auto-repeat while a button is held.
module pmod_btn_reader
  import pmod_btn_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
`ifdef PMOD_BTN_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_CH-1:0]     PMOD_IN,
  output logic [N_CH-1:0]     BTN_STATE,
  output logic [N_CH-1:0]     BTN_PRESS,
  output logic [N_CH-1:0]     BTN_RELEASE,
  output logic                EVT_VALID,
  input  logic                EVT_READY,
  output logic [EVT_ID_W-1:0] EVT_ID,
  output logic                EVT_PRESS,
  output logic                OVERRUN,
  output logic                DBG_EVT_STATE
);
  // Event port: EVT_ID/EVT_PRESS are stable whenever EVT_VALID is high; an event
  // transfers on a rising CLK edge with EVT_VALID && EVT_READY, then EVT_VALID drops for one cycle.
  logic [TICK_DIV-1:0] presc;
  logic                tick;
  logic [N_CH-1:0]     press_pend, rel_pend, clr_press, clr_rel;
  evt_state_t          state_q, state_d;
  logic                valid_d, evt_press_d;
  logic [EVT_ID_W-1:0] evt_id_d;
  logic                sel_any, sel_press;
  logic [EVT_ID_W-1:0] sel_id;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc <= '0;
    else     presc <= presc + 1'b1;
  end

  assign tick = &presc;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pmod_btn_debounce #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef PMOD_BTN_AUTOREPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_db (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .pin_n(PMOD_IN[g]),
      .level(BTN_STATE[g]),
      .press(BTN_PRESS[g]),
      .rel  (BTN_RELEASE[g])
    );
  end

  // Descending scan so the lowest pending channel wins; press beats release.
  always_comb begin
    sel_any   = 1'b0;
    sel_press = 1'b0;
    sel_id    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_pend[i] || rel_pend[i]) begin
        sel_any   = 1'b1;
        sel_press = press_pend[i];
        sel_id    = EVT_ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = EVT_VALID;
    evt_id_d    = EVT_ID;
    evt_press_d = EVT_PRESS;
    clr_press   = '0;
    clr_rel     = '0;
    case (state_q)
      EVT_IDLE: begin
        if (sel_any) begin
          state_d     = EVT_SHOW;
          valid_d     = 1'b1;
          evt_id_d    = sel_id;
          evt_press_d = sel_press;
        end
      end
      EVT_SHOW: begin
        if (EVT_READY) begin
          state_d = EVT_IDLE;
          valid_d = 1'b0;
          for (int i = 0; i < N_CH; i++) begin
            if (EVT_ID == EVT_ID_W'(i)) begin
              clr_press[i] = EVT_PRESS;
              clr_rel[i]   = !EVT_PRESS;
            end
          end
        end
      end
      default: state_d = EVT_IDLE;
    endcase
  end

  // A new strobe always re-sets its pending bit, even in the cycle it is consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= EVT_IDLE;
      EVT_VALID  <= 1'b0;
      EVT_ID     <= '0;
      EVT_PRESS  <= 1'b0;
      press_pend <= '0;
      rel_pend   <= '0;
      OVERRUN    <= 1'b0;
    end else begin
      state_q    <= state_d;
      EVT_VALID  <= valid_d;
      EVT_ID     <= evt_id_d;
      EVT_PRESS  <= evt_press_d;
      press_pend <= (press_pend & ~clr_press) | BTN_PRESS;
      rel_pend   <= (rel_pend & ~clr_rel) | BTN_RELEASE;
      if (|((BTN_PRESS & press_pend & ~clr_press) | (BTN_RELEASE & rel_pend & ~clr_rel)))
        OVERRUN <= 1'b1;
    end
  end

  assign DBG_EVT_STATE = (state_q == EVT_SHOW);
endmodule

// File: tb/tb_pmod_btn_reader.sv
// Directed + random bench for pmod_btn_reader against a cycle-level behavioural model.
// Build with PMOD_BTN_AUTOREPEAT_EN to exercise the auto-repeat variant.
module tb_pmod_btn_reader;
  localparam int N_CH     = 8;
  localparam int TICK_DIV = 2;
  localparam int ST       = 3;
  localparam int TICK_P   = 1 << TICK_DIV;
  localparam int RD       = 4;
  localparam int RR       = 2;
`ifdef PMOD_BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N_CH-1:0] PMOD_IN = '1;
  logic            EVT_READY = 1'b1;
  logic [N_CH-1:0] BTN_STATE, BTN_PRESS, BTN_RELEASE;
  logic            EVT_VALID, EVT_PRESS, OVERRUN, DBG_EVT_STATE;
  logic [2:0]      EVT_ID;

  pmod_btn_reader #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(ST)
`ifdef PMOD_BTN_AUTOREPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .PMOD_IN(PMOD_IN),
    .BTN_STATE(BTN_STATE), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ID(EVT_ID),
    .EVT_PRESS(EVT_PRESS), .OVERRUN(OVERRUN), .DBG_EVT_STATE(DBG_EVT_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  logic [N_CH-1:0] m_s1, m_s2, m_state, m_press, m_rel, m_pp, m_rp;
  int              m_run[N_CH];
  int              m_hold[N_CH];
  int              m_edges;
  logic            m_valid, m_epress, m_ovr;
  logic [2:0]      m_id;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_state = '0; m_press = '0; m_rel = '0;
    m_pp = '0; m_rp = '0; m_edges = 0;
    m_valid = 1'b0; m_epress = 1'b0; m_ovr = 1'b0; m_id = '0;
    for (int i = 0; i < N_CH; i++) begin m_run[i] = 0; m_hold[i] = 0; end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] raw, clr_p, clr_r, n_press, n_rel;
    bit tick, found;
    raw   = ~m_s2;
    tick  = (m_edges % TICK_P) == (TICK_P - 1);
    m_edges++;
    clr_p = '0; clr_r = '0;
    // event port: accept the shown event, or show the lowest pending one
    if (m_valid) begin
      if (EVT_READY) begin
        m_valid = 1'b0;
        if (m_epress) clr_p[m_id] = 1'b1; else clr_r[m_id] = 1'b1;
      end
    end else begin
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (!found && (m_pp[i] || m_rp[i])) begin
          found = 1'b1; m_valid = 1'b1; m_id = 3'(i); m_epress = m_pp[i];
        end
      end
    end
    for (int i = 0; i < N_CH; i++)
      if ((m_press[i] && m_pp[i] && !clr_p[i]) || (m_rel[i] && m_rp[i] && !clr_r[i])) m_ovr = 1'b1;
    m_pp = (m_pp & ~clr_p) | m_press;
    m_rp = (m_rp & ~clr_r) | m_rel;
    // debounce: a level changes after ST consecutive differing tick samples
    n_press = '0; n_rel = '0;
    if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        if (raw[i] == m_state[i]) m_run[i] = 0;
        else                      m_run[i]++;
        if (m_run[i] == ST) begin
          m_state[i] = raw[i]; m_run[i] = 0; m_hold[i] = 0;
          n_press[i] = raw[i]; n_rel[i] = ~raw[i];
        end else if (AR && m_state[i]) begin
          m_hold[i]++;
          if (m_hold[i] == RD || (m_hold[i] > RD && ((m_hold[i] - RD) % RR) == 0)) n_press[i] = 1'b1;
        end
      end
    end
    m_press = n_press; m_rel = n_rel;
    m_s2 = m_s1; m_s1 = PMOD_IN;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step();
  end

  // ---------------- scoreboard ----------------
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc_n    = 0;
  int         press_cnt[N_CH];
  int         valid_seen;
  logic [3:0] acc_q[$];
  logic [3:0] exp_q[$];
  int         p7_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {BTN_STATE, BTN_PRESS, BTN_RELEASE, EVT_VALID, EVT_ID, EVT_PRESS, OVERRUN}, 32'h0);
  endtask

  task automatic clear_logs();
    acc_q.delete(); exp_q.delete(); p7_q.delete(); valid_seen = 0;
    for (int i = 0; i < N_CH; i++) press_cnt[i] = 0;
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk(tag, (k < acc_q.size()) ? acc_q[k] : 4'hx, exp_q[k]);
  endtask

  // driver step: log accepts, advance to the falling edge, compare against the model
  task automatic cyc();
    if (EVT_VALID === 1'b1 && EVT_READY) acc_q.push_back({EVT_ID, EVT_PRESS});
    @(negedge CLK);
    cyc_n++;
    for (int i = 0; i < N_CH; i++) if (BTN_PRESS[i] === 1'b1) press_cnt[i]++;
    if (BTN_PRESS[7] === 1'b1) p7_q.push_back(cyc_n);
    if (EVT_VALID === 1'b1) valid_seen++;
    chk("btn", {8'h0, BTN_STATE, BTN_PRESS, BTN_RELEASE}, {8'h0, m_state, m_press, m_rel});
    chk("evt", {EVT_VALID, DBG_EVT_STATE, EVT_VALID ? {EVT_ID, EVT_PRESS} : 4'h0, OVERRUN},
               {m_valid, m_valid, m_valid ? {m_id, m_epress} : 4'h0, m_ovr});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_level(input int ch, input logic val, input string tag);
    int n;
    n = 0;
    while (BTN_STATE[ch] !== val && n < 30) begin cyc(); n++; end
    chk(tag, BTN_STATE[ch], val);
  endtask

  int first, bad, ch;

  initial begin
    #1 RST = 1'b1;
    #1 chk_reset("reset_state");
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    run(4);

    // 1: clean press on ch2
    clear_logs(); first = -1;
    PMOD_IN[2] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (first < 0 && BTN_STATE[2] === 1'b1) first = k + 1;
    end
    chk("t1_latency", (first > 0 && first <= 18), 1);
    chk("t1_press_pulses", press_cnt[2], 1);
    PMOD_IN[2] = 1'b1;
    run(30);
    exp_q = '{4'b0101, 4'b0100};
    cmp_events("t1_events");

    // 2: short glitch on ch0 is filtered
    clear_logs();
    PMOD_IN[0] = 1'b0; run(6);
    PMOD_IN[0] = 1'b1; run(30);
    chk("t2_press_pulses", press_cnt[0], 0);
    chk("t2_no_event", valid_seen, 0);

    // 3: simultaneous ch5 + ch1 with consumer stalled
    clear_logs(); bad = 0;
    EVT_READY = 1'b0;
    PMOD_IN[5] = 1'b0; PMOD_IN[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (EVT_VALID === 1'b1 && {EVT_ID, EVT_PRESS} !== 4'b0011) bad++;
    end
    chk("t3_valid_held", EVT_VALID, 1);
    chk("t3_id_first", EVT_ID, 3'd1);
    chk("t3_stable", bad, 0);
    EVT_READY = 1'b1;
    run(10);
    exp_q = '{4'b0011, 4'b1011};
    cmp_events("t3_order");
    PMOD_IN[5] = 1'b1; PMOD_IN[1] = 1'b1;
    run(30);

    // 4: second press strobe while press still pending -> sticky OVERRUN
    chk("t4_overrun_clear", OVERRUN, 0);
    EVT_READY = 1'b0;
    PMOD_IN[3] = 1'b0; wait_level(3, 1'b1, "t4_press1");
    PMOD_IN[3] = 1'b1; wait_level(3, 1'b0, "t4_release");
    PMOD_IN[3] = 1'b0; wait_level(3, 1'b1, "t4_press2");
    run(2);
    chk("t4_overrun_set", OVERRUN, 1);
    EVT_READY = 1'b1; PMOD_IN[3] = 1'b1;
    run(40);
    chk("t4_overrun_sticky", OVERRUN, 1);
    chk("t4_drained", EVT_VALID, 0);

    // 5a: async reset mid-debounce
    PMOD_IN[6] = 1'b0; run(8);
    #2 RST = 1'b1;
    #1 chk_reset("t5_rst_mid_debounce");
    PMOD_IN = '1;
    @(negedge CLK); RST = 1'b0;
    clear_logs(); run(30);
    chk("t5_no_event_a", valid_seen, 0);
    chk("t5_idle_state_a", BTN_STATE, 0);
    // 5b: async reset while an event is shown
    EVT_READY = 1'b0; PMOD_IN[4] = 1'b0;
    first = 0;
    while (EVT_VALID !== 1'b1 && first < 30) begin cyc(); first++; end
    chk("t5_valid_before_rst", EVT_VALID, 1);
    #2 RST = 1'b1;
    #1 chk_reset("t5_rst_in_handshake");
    PMOD_IN = '1; EVT_READY = 1'b1;
    @(negedge CLK); RST = 1'b0;
    clear_logs(); run(30);
    chk("t5_no_event_b", valid_seen, 0);

    // 6: long hold on ch7 (auto-repeat when built with it)
    clear_logs();
    PMOD_IN[7] = 1'b0; run(60 * TICK_P);
    PMOD_IN[7] = 1'b1; run(40);
    if (AR) begin
      chk("t6_repeat_count_ok", p7_q.size() >= 20, 1);
      for (int k = 1; k < p7_q.size(); k++)
        chk("t6_repeat_gap", p7_q[k] - p7_q[k-1], (k == 1) ? RD * TICK_P : RR * TICK_P);
    end else begin
      chk("t6_single_press", p7_q.size(), 1);
    end

    // random pins and consumer stalls, checked cycle by cycle against the model
    for (int k = 0; k < 1500; k++) begin
      EVT_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, N_CH - 1);
        PMOD_IN[ch] = ~PMOD_IN[ch];
      end
      cyc();
    end
    PMOD_IN = '1; EVT_READY = 1'b1;
    run(100);
    chk("final_drained", EVT_VALID, 0);
    chk("final_levels", BTN_STATE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
